// File: rtl/mux_source_arbiter.sv
// Round-robin owner arbiter for the shared 4-input source mux, with a park gap between owners.
// Optional ownership timeout/preemption is built only when MUX_ARB_TIMEOUT_EN is defined.
module mux_source_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  localparam logic [2:0] SEL_PARK = 3'd4;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       preempt_q, preempt_d;
`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       others_pending;
`endif

  logic       win_valid;
  logic [1:0] win_idx;

  // Scan from ptr downwards in priority; the last hit (lowest offset) wins.
  always_comb begin
    logic [1:0] idx;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  assign others_pending = (req & ~(4'b0001 << owner_q)) != 4'b0000;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gap_cnt_d = gap_cnt_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = OWN;
          owner_d = win_idx;
          grant_d = 4'b0001 << win_idx;
          sel_d   = {1'b0, win_idx};
          busy_d  = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
        end
      end

      OWN: begin
`ifdef MUX_ARB_TIMEOUT_EN
        if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
        if (!req[owner_q] || (hold_cnt_q >= 8'(MAX_HOLD - 1) && others_pending)) begin
          preempt_d = req[owner_q];
`else
        if (!req[owner_q]) begin
`endif
          state_d   = GAP;
          ptr_d     = owner_q + 2'd1;
          gap_cnt_d = 4'd0;
          grant_d   = 4'b0000;
          sel_d     = SEL_PARK;
          busy_d    = 1'b0;
        end
      end

      GAP: begin
        if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
          if (win_valid) begin
            state_d = OWN;
            owner_d = win_idx;
            grant_d = 4'b0001 << win_idx;
            sel_d   = {1'b0, win_idx};
            busy_d  = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_d = 8'd0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        sel_d   = SEL_PARK;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      gap_cnt_q <= 4'd0;
      grant_q   <= 4'b0000;
      sel_q     <= SEL_PARK;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gap_cnt_q <= gap_cnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_mux_source_arbiter.sv
// Directed self-checking bench for mux_source_arbiter: one DUT with a 1-cycle gap, one with a 3-cycle gap.
module tb_mux_source_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;
  logic [3:0] req3;
  logic [3:0] grant3;
  logic [2:0] sel3;
  logic       busy3;
  logic       preempt3;

  int checks;
  int errors;

  mux_source_arbiter #(.GAP_CYCLES(1), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant), .sel(sel), .busy(busy), .preempt(preempt)
  );

  mux_source_arbiter #(.GAP_CYCLES(3), .MAX_HOLD(8)) dut3 (
    .clk(clk), .reset(reset), .req(req3),
    .grant(grant3), .sel(sel3), .busy(busy3), .preempt(preempt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    req   = 4'b0000;
    req3  = 4'b0000;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    req3  = 4'b1111;
    repeat (3) tick();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
    checks++;
    if (sel !== 3'd4) begin errors++; $display("[TB] FAIL reset_sel got %0d want 4", sel); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (preempt !== 1'b0) begin errors++; $display("[TB] FAIL reset_preempt got %b want 0", preempt); end
    req   = 4'b0000;
    req3  = 4'b0000;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || sel !== 3'd4 || busy !== 1'b0 || preempt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle cyc %0d got g=%b s=%0d b=%b p=%b want g=0000 s=4 b=0 p=0",
                 i, grant, sel, busy, preempt);
      end
    end
  endtask

  task automatic test_single_owner();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || sel !== 3'd2 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL single_own cyc %0d got g=%b s=%0d b=%b want g=0100 s=2 b=1", i, grant, sel, busy);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || sel !== 3'd4 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_gap got g=%b s=%0d b=%b want g=0000 s=4 b=0", grant, sel, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || sel !== 3'd4) begin
      errors++;
      $display("[TB] FAIL single_idle got g=%b s=%0d want g=0000 s=4", grant, sel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    pulse_reset();
    req = 4'b1111;
    for (int o = 0; o < 4; o++) begin
      exp_g = 4'b0001 << o;
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (grant !== exp_g || sel !== 3'(o)) begin
          errors++;
          $display("[TB] FAIL rr_own owner %0d cyc %0d got g=%b s=%0d want g=%b s=%0d", o, c, grant, sel, exp_g, o);
        end
      end
      req = 4'b1111 & ~exp_g;
      tick();
      checks++;
      if (grant !== 4'b0000 || sel !== 3'd4) begin
        errors++;
        $display("[TB] FAIL rr_gap after owner %0d got g=%b s=%0d want g=0000 s=4", o, grant, sel);
      end
      req = 4'b1111;
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || sel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rr_wrap got g=%b s=%0d want g=0001 s=0", grant, sel);
    end
  endtask

  task automatic test_gap3();
    pulse_reset();
    req3 = 4'b0010;
    tick();
    checks++;
    if (grant3 !== 4'b0010 || sel3 !== 3'd1) begin
      errors++;
      $display("[TB] FAIL gap3_own1 got g=%b s=%0d want g=0010 s=1", grant3, sel3);
    end
    req3 = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant3 !== 4'b0000 || sel3 !== 3'd4 || busy3 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gap3_park cyc %0d got g=%b s=%0d b=%b want g=0000 s=4 b=0", i, grant3, sel3, busy3);
      end
    end
    tick();
    checks++;
    if (grant3 !== 4'b1000 || sel3 !== 3'd3 || busy3 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gap3_own3 got g=%b s=%0d b=%b want g=1000 s=3 b=1", grant3, sel3, busy3);
    end
    req3 = 4'b0000;
  endtask

  task automatic test_timeout();
    pulse_reset();
    req = 4'b0011;
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || sel !== 3'd0 || preempt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_hold cyc %0d got g=%b s=%0d p=%b want g=0001 s=0 p=0", i, grant, sel, preempt);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || sel !== 3'd4 || preempt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_preempt got g=%b s=%0d p=%b want g=0000 s=4 p=1", grant, sel, preempt);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || sel !== 3'd1 || preempt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_next got g=%b s=%0d p=%b want g=0010 s=1 p=0", grant, sel, preempt);
    end
`else
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || sel !== 3'd0 || preempt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL no_timeout_hold cyc %0d got g=%b s=%0d p=%b want g=0001 s=0 p=0", i, grant, sel, preempt);
      end
    end
`endif
    pulse_reset();
    req = 4'b0001;
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || preempt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sole_owner_hold cyc %0d got g=%b p=%b want g=0001 p=0", i, grant, preempt);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100 || sel !== 3'd2) begin
      errors++;
      $display("[TB] FAIL async_pre_own got g=%b s=%0d want g=0100 s=2", grant, sel);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || sel !== 3'd4 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got g=%b s=%0d b=%b want g=0000 s=4 b=0", grant, sel, busy);
    end
    tick();
    req   = 4'b1100;
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0100 || sel !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_after got g=%b s=%0d b=%b want g=0100 s=2 b=1", grant, sel, busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = 4'b0000;
    req3   = 4'b0000;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_gap3();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
